cart_mem_arbiter: RTL and testbench
===================================

Name: cart_mem_arbiter

Overview:
- Shares the single byte-wide cartridge ROM memory port between three requesters:
  - the ioctl download writer (CPR/BIN load);
  - Z80 cartridge reads, already bank-translated to a 23-bit address;
  - ASIC DMA sound-channel fetches.
- Fixed priority: download > CPU > DMA.
- Anti-starvation guard for DMA, one transaction in flight, and a memory-ack timeout.
- Sits between the cartridge bank logic and the SDRAM/BRAM ROM controller.

Parameters:
- ADDR_W, 23, memory address width.
- STARVE_MAX, 4, consecutive CPU grants allowed while DMA waits before DMA is forced next.
- TIMEOUT, 64, cycles to wait for mem_ack before aborting a transaction.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high.
- dl_wr  in  1  one-cycle download write strobe.
- dl_addr  in  ADDR_W  download byte address.
- dl_data  in  8  download byte.
- dl_wait  out  1  download backpressure; the source must hold off further dl_wr while it is high.
- cpu_req  in  1  level request; held until cpu_ack.
- cpu_addr  in  ADDR_W  CPU read address.
- cpu_rdata  out  8  CPU read data, valid with cpu_ack.
- cpu_ack  out  1  one-cycle completion pulse.
- dma_req  in  1  level request; held until dma_ack.
- dma_addr  in  ADDR_W  DMA read address.
- dma_rdata  out  8  DMA read data, valid with dma_ack.
- dma_ack  out  1  one-cycle completion pulse.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  memory address.
- mem_din  out  8  write data.
- mem_dout  in  8  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion from the memory controller.
- timeout_err  out  1  sticky; set on any timeout, cleared only by reset.

Behaviour:
- Reset values: all outputs 0, state IDLE, download buffer empty, starve counter 0, watchdog 0.
- Download buffer (single entry):
  - dl_wr with the buffer empty: capture addr/data; buffer becomes pending.
  - dl_wait = pending.
  - dl_wr while pending: dropped, no state change. This is a protocol violation that the bench flags.
- State machine:
  - IDLE:
    - Select a requester: download pending > (DMA if starve == STARVE_MAX and dma_req) > cpu_req > dma_req.
    - Latch the owner, mem_addr, mem_we and mem_din. Go to BUSY with mem_req = 1 on the next cycle.
    - If nothing is requesting, stay in IDLE.
  - BUSY:
    - mem_req, mem_we, mem_addr and mem_din stay stable while the watchdog counts.
    - On mem_ack: mem_req drops the same edge. For a read, latch mem_dout into the owner's rdata and pulse the owner's ack at the next cycle. For a download, clear the pending flag (dl_wait falls the next cycle). Go to IDLE.
    - If the watchdog reaches TIMEOUT-1 without mem_ack: drop mem_req and set timeout_err. A read owner receives rdata = 8'hFF with its ack pulse; a download simply clears pending. Go to IDLE.
- Latency: request visible at edge N → mem_req high from N+1. mem_ack at edge M → requester ack high during cycle M+1. With a 1-cycle memory, CPU read round trip is 3 cycles.
- A new grant is evaluated in IDLE, so back-to-back transactions are separated by one IDLE cycle.
- Starve counter:
  - Increments when the CPU is granted while dma_req = 1.
  - Clears when DMA is granted or dma_req = 0.
  - Saturates at STARVE_MAX.
  - Download grants neither increment nor clear it.
- Simultaneous events:
  - mem_ack and a new dl_wr on the same edge: dl_wr is accepted only if pending was already 0, so it is dropped while BUSY with a download.
  - A requester dropping req before its ack is illegal. The arbiter completes the transaction anyway and pulses ack.
  - Addresses and data are sampled only at grant. Later changes on cpu_addr or dma_addr do not affect an in-flight access.
- Reset mid-transaction: everything returns to IDLE immediately and mem_req = 0. The memory controller shares the reset and discards the partial access.
- rdata holds its last value between acks.

Decomposition:
- Shared package cart_mem_pkg:
  - owner enum: OWN_NONE, OWN_DL, OWN_CPU, OWN_DMA.
  - state enum: IDLE, BUSY.
  - TIMEOUT_DATA = 8'hFF.
- One natural sub-module, cart_arb_prio: combinational priority/starvation selector taking pending, cpu_req, dma_req and the starve count, returning the owner. It is unit-testable in isolation.
- Buffer, watchdog and FSM stay in the top level.

Test Plan:
- CPU read only, memory ack 1 cycle after mem_req, mem_dout = 8'h5A: mem_req high cycle N+1, mem_we = 0, cpu_ack at N+3, cpu_rdata = 8'h5A.
- dl_wr, cpu_req and dma_req on the same cycle: grant order is download, CPU, DMA. dl_wait is high until the download ack. mem_we = 1 only on the first transaction.
- cpu_req held continuously with dma_req high, STARVE_MAX = 4: exactly 4 CPU grants, then 1 DMA grant, then CPU resumes.
- Memory never acks, TIMEOUT = 64, CPU read: mem_req drops after 64 cycles, cpu_ack pulses with rdata = 8'hFF, timeout_err stays 1 until reset.
- Download of 256 bytes with dl_wr issued only when dl_wait = 0: 256 memory writes with matching addr/data in order, none dropped.
- Reset asserted mid-BUSY with a DMA read outstanding: next cycle mem_req = 0, dma_ack never pulses, timeout_err = 0, and a fresh CPU read afterwards completes normally.

Source files
------------

// File: rtl/cart_mem_pkg.sv
// rtl/cart_mem_pkg.sv - shared types and constants for the cartridge memory arbiter.
package cart_mem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_DL,
        OWN_CPU,
        OWN_DMA
    } owner_t;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    // Read data returned to a requester whose access timed out
    localparam logic [7:0] TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/cart_arb_prio.sv
// rtl/cart_arb_prio.sv - combinational owner selection: download > starved DMA > CPU > DMA.
module cart_arb_prio
    import cart_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int STARVE_W   = 3
) (
    input  logic                pending,
    input  logic                cpu_req,
    input  logic                dma_req,
    input  logic [STARVE_W-1:0] starve,
    output owner_t              owner
);

    always_comb begin
        owner = OWN_NONE;
        if (pending) begin
            owner = OWN_DL;
        end else if (dma_req && (starve >= STARVE_W'(STARVE_MAX))) begin
            owner = OWN_DMA;
        end else if (cpu_req) begin
            owner = OWN_CPU;
        end else if (dma_req) begin
            owner = OWN_DMA;
        end
    end

endmodule

// File: rtl/cart_mem_arbiter.sv
// rtl/cart_mem_arbiter.sv - shares the cartridge ROM port between download, CPU and DMA.
module cart_mem_arbiter
    import cart_mem_pkg::*;
#(
    parameter int ADDR_W     = 23,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    output logic              dl_wait,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    output logic [7:0]        dma_rdata,
    output logic              dma_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout,
    input  logic              mem_ack,
    output logic              timeout_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    state_t            state, state_nxt;
    owner_t            owner_q, sel;
    logic              pending;
    logic [ADDR_W-1:0] dl_addr_q;
    logic [7:0]        dl_data_q;
    logic [SW-1:0]     starve;
    logic [WW-1:0]     wdog;
    logic              grant, fin_ack, fin_to, finish, dl_take, wdog_end;

    // An empty buffer lets a fresh dl_wr win arbitration on the very edge it is captured
    assign dl_take  = dl_wr && !pending;
    assign dl_wait  = pending;
    assign wdog_end = (wdog == WW'(TIMEOUT - 1));
    assign finish   = fin_ack || fin_to;

    cart_arb_prio #(
        .STARVE_MAX (STARVE_MAX),
        .STARVE_W   (SW)
    ) u_prio (
        .pending (pending || dl_wr),
        .cpu_req (cpu_req),
        .dma_req (dma_req),
        .starve  (starve),
        .owner   (sel)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant)  state_nxt = BUSY;
            BUSY:    if (finish) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant   = 1'b0;
        fin_ack = 1'b0;
        fin_to  = 1'b0;
        mem_req = 1'b0;
        case (state)
            IDLE: grant = (sel != OWN_NONE);
            BUSY: begin
                mem_req = 1'b1;
                fin_ack = mem_ack;
                fin_to  = !mem_ack && wdog_end;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            owner_q     <= OWN_NONE;
            pending     <= 1'b0;
            dl_addr_q   <= '0;
            dl_data_q   <= '0;
            starve      <= '0;
            wdog        <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            cpu_rdata   <= '0;
            cpu_ack     <= 1'b0;
            dma_rdata   <= '0;
            dma_ack     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            if (dl_take) begin
                pending   <= 1'b1;
                dl_addr_q <= dl_addr;
                dl_data_q <= dl_data;
            end
            if (grant) begin
                owner_q <= sel;
                wdog    <= '0;
                if (sel == OWN_DL) begin
                    mem_we   <= 1'b1;
                    mem_addr <= pending ? dl_addr_q : dl_addr;
                    mem_din  <= pending ? dl_data_q : dl_data;
                end else begin
                    mem_we   <= 1'b0;
                    mem_addr <= (sel == OWN_CPU) ? cpu_addr : dma_addr;
                    mem_din  <= '0;
                end
            end else if (state == BUSY && !finish) begin
                wdog <= wdog + 1'b1;
            end
            if (finish) begin
                case (owner_q)
                    OWN_DL:  pending <= 1'b0;
                    OWN_CPU: begin
                        cpu_ack   <= 1'b1;
                        cpu_rdata <= fin_ack ? mem_dout : TIMEOUT_DATA;
                    end
                    OWN_DMA: begin
                        dma_ack   <= 1'b1;
                        dma_rdata <= fin_ack ? mem_dout : TIMEOUT_DATA;
                    end
                    default: ;
                endcase
            end
            if (fin_to) timeout_err <= 1'b1;
            if (!dma_req || (grant && sel == OWN_DMA)) begin
                starve <= '0;
            end else if (grant && sel == OWN_CPU && starve != SW'(STARVE_MAX)) begin
                starve <= starve + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// tb/tb_cart_mem_arbiter.sv - directed self-checking bench for cart_mem_arbiter.
module tb_cart_mem_arbiter;

    logic        clk_sys;
    logic        reset;
    logic        dl_wr;
    logic [22:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_wait;
    logic        cpu_req;
    logic [22:0] cpu_addr;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        dma_req;
    logic [22:0] dma_addr;
    logic [7:0]  dma_rdata;
    logic        dma_ack;
    logic        mem_req;
    logic        mem_we;
    logic [22:0] mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic        mem_ack;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;

    logic        mem_en;
    int          mem_lat;
    int          mem_cnt;
    bit          q_we[$];
    logic [22:0] q_addr[$];
    logic [7:0]  q_din[$];
    logic [22:0] t3_exp[6];

    cart_mem_arbiter #(
        .ADDR_W     (23),
        .STARVE_MAX (4),
        .TIMEOUT    (64)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .dl_wr       (dl_wr),
        .dl_addr     (dl_addr),
        .dl_data     (dl_data),
        .dl_wait     (dl_wait),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_rdata   (cpu_rdata),
        .cpu_ack     (cpu_ack),
        .dma_req     (dma_req),
        .dma_addr    (dma_addr),
        .dma_rdata   (dma_rdata),
        .dma_ack     (dma_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_dout    (mem_dout),
        .mem_ack     (mem_ack),
        .timeout_err (timeout_err)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // Memory responder: logs each access once, acks after mem_lat further cycles of mem_req
    initial begin
        mem_ack = 1'b0;
        mem_cnt = 0;
        forever begin
            @(negedge clk_sys);
            if (reset || !mem_req) begin
                mem_ack = 1'b0;
                mem_cnt = 0;
            end else begin
                if (mem_cnt == 0) begin
                    q_we.push_back(mem_we);
                    q_addr.push_back(mem_addr);
                    q_din.push_back(mem_din);
                end
                mem_ack = mem_en && (mem_cnt == mem_lat);
                mem_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        dl_wr   = 1'b0;
        cpu_req = 1'b0;
        dma_req = 1'b0;
        step();
        step();
        reset = 1'b0;
        q_we.delete();
        q_addr.delete();
        q_din.delete();
    endtask

    initial begin
        int  cnt;
        int  bad;
        int  stall;
        bit  cpu_done;
        bit  dma_done;
        bit  seen;

        reset    = 1'b1;
        dl_wr    = 1'b0;
        dl_addr  = '0;
        dl_data  = '0;
        cpu_req  = 1'b0;
        cpu_addr = '0;
        dma_req  = 1'b0;
        dma_addr = '0;
        mem_dout = '0;
        mem_en   = 1'b1;
        mem_lat  = 1;
        t3_exp[0] = 23'h11; t3_exp[1] = 23'h11; t3_exp[2] = 23'h11;
        t3_exp[3] = 23'h11; t3_exp[4] = 23'h22; t3_exp[5] = 23'h11;
        do_reset();

        chk("rst_mem_req", mem_req, 0);
        chk("rst_dl_wait", dl_wait, 0);
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_dma_ack", dma_ack, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);

        // Single CPU read, 1-cycle memory
        mem_dout = 8'h5A;
        cpu_req  = 1'b1;
        cpu_addr = 23'h01234;
        step();
        chk("t1_mem_req_n1", mem_req, 1);
        chk("t1_mem_we", mem_we, 0);
        chk("t1_mem_addr", mem_addr, 32'h01234);
        step();
        chk("t1_mem_req_n2", mem_req, 1);
        chk("t1_cpu_ack_n2", cpu_ack, 0);
        step();
        chk("t1_mem_req_n3", mem_req, 0);
        chk("t1_cpu_ack_n3", cpu_ack, 1);
        chk("t1_cpu_rdata", cpu_rdata, 32'h5A);
        cpu_req = 1'b0;
        step();
        chk("t1_cpu_ack_n4", cpu_ack, 0);
        chk("t1_rdata_hold", cpu_rdata, 32'h5A);
        chk("t1_no_regrant", mem_req, 0);

        // Simultaneous download, CPU and DMA requests
        do_reset();
        mem_dout = 8'h81;
        dl_wr    = 1'b1;
        dl_addr  = 23'h100;
        dl_data  = 8'h3C;
        cpu_req  = 1'b1;
        cpu_addr = 23'h200;
        dma_req  = 1'b1;
        dma_addr = 23'h300;
        step();
        dl_wr = 1'b0;
        chk("t2_dl_first_we", mem_we, 1);
        chk("t2_dl_first_addr", mem_addr, 32'h100);
        chk("t2_dl_first_din", mem_din, 32'h3C);
        chk("t2_dl_wait_a", dl_wait, 1);
        step();
        chk("t2_dl_wait_b", dl_wait, 1);
        step();
        chk("t2_dl_wait_clear", dl_wait, 0);
        cpu_done = 1'b0;
        dma_done = 1'b0;
        for (int i = 0; i < 40 && !(cpu_done && dma_done); i++) begin
            step();
            if (cpu_ack) begin
                cpu_done = 1'b1;
                cpu_req  = 1'b0;
            end
            if (dma_ack) begin
                dma_done = 1'b1;
                dma_req  = 1'b0;
            end
        end
        chk("t2_cpu_done", cpu_done, 1);
        chk("t2_dma_done", dma_done, 1);
        chk("t2_dma_rdata", dma_rdata, 32'h81);
        chk("t2_log_size", q_addr.size(), 3);
        chk("t2_order0", {q_we[0], 8'h0, q_addr[0]}, {1'b1, 8'h0, 23'h100});
        chk("t2_order1", {q_we[1], 8'h0, q_addr[1]}, {1'b0, 8'h0, 23'h200});
        chk("t2_order2", {q_we[2], 8'h0, q_addr[2]}, {1'b0, 8'h0, 23'h300});

        // CPU hogging with DMA waiting: four CPU grants then one forced DMA grant
        do_reset();
        cpu_req  = 1'b1;
        cpu_addr = 23'h11;
        dma_req  = 1'b1;
        dma_addr = 23'h22;
        for (int i = 0; i < 200 && q_addr.size() < 6; i++) step();
        chk("t3_grant_count", q_addr.size() >= 6, 1);
        for (int k = 0; k < 6; k++) begin
            if (k < q_addr.size()) chk($sformatf("t3_grant%0d", k), q_addr[k], t3_exp[k]);
        end

        // Memory never acks: watchdog abort
        do_reset();
        mem_en   = 1'b0;
        cpu_req  = 1'b1;
        cpu_addr = 23'h55;
        step();
        cnt = 0;
        for (int i = 0; i < 200 && mem_req; i++) begin
            cnt++;
            step();
        end
        chk("t4_req_cycles", cnt, 64);
        chk("t4_mem_req_low", mem_req, 0);
        chk("t4_cpu_ack", cpu_ack, 1);
        chk("t4_cpu_rdata", cpu_rdata, 32'hFF);
        chk("t4_timeout_set", timeout_err, 1);
        cpu_req = 1'b0;
        step();
        chk("t4_cpu_ack_off", cpu_ack, 0);
        step();
        step();
        step();
        chk("t4_timeout_sticky", timeout_err, 1);
        mem_en = 1'b1;
        do_reset();
        chk("t4_timeout_reset", timeout_err, 0);

        // 256-byte download honouring dl_wait, 2-cycle memory
        mem_lat = 2;
        stall   = 0;
        for (int i = 0; i < 256; i++) begin
            for (int w = 0; w < 20 && dl_wait; w++) step();
            if (dl_wait) stall++;
            dl_wr   = 1'b1;
            dl_addr = 23'h4000 + 23'(i);
            dl_data = 8'(i) ^ 8'h96;
            step();
            dl_wr = 1'b0;
        end
        for (int w = 0; w < 20 && (dl_wait || mem_req); w++) step();
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            if (k >= q_addr.size()) bad++;
            else if (q_we[k] !== 1'b1 || q_addr[k] !== 23'h4000 + 23'(k) ||
                     q_din[k] !== (8'(k) ^ 8'h96)) bad++;
        end
        chk("t5_stalls", stall, 0);
        chk("t5_log_size", q_addr.size(), 256);
        chk("t5_log_bad", bad, 0);

        // dl_wr while pending is dropped
        do_reset();
        mem_lat = 3;
        dl_wr   = 1'b1;
        dl_addr = 23'h10;
        dl_data = 8'h11;
        step();
        chk("t5b_dl_wait", dl_wait, 1);
        dl_addr = 23'h20;
        dl_data = 8'h22;
        step();
        dl_wr = 1'b0;
        for (int w = 0; w < 20 && (dl_wait || mem_req); w++) step();
        chk("t5b_log_size", q_addr.size(), 1);
        chk("t5b_addr", q_addr[0], 32'h10);
        chk("t5b_din", q_din[0], 32'h11);

        // Reset in the middle of an outstanding DMA read
        do_reset();
        mem_en   = 1'b0;
        mem_lat  = 1;
        dma_req  = 1'b1;
        dma_addr = 23'h77;
        step();
        chk("t6_mem_req_busy", mem_req, 1);
        step();
        step();
        step();
        reset = 1'b1;
        step();
        chk("t6_mem_req_reset", mem_req, 0);
        chk("t6_dma_ack_reset", dma_ack, 0);
        chk("t6_timeout_reset", timeout_err, 0);
        reset   = 1'b0;
        dma_req = 1'b0;
        seen    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (dma_ack) seen = 1'b1;
        end
        chk("t6_dma_ack_never", seen, 0);
        mem_en   = 1'b1;
        mem_dout = 8'hC3;
        cpu_req  = 1'b1;
        cpu_addr = 23'h99;
        step();
        chk("t6_cpu_mem_req", mem_req, 1);
        chk("t6_cpu_addr", mem_addr, 32'h99);
        step();
        step();
        chk("t6_cpu_ack", cpu_ack, 1);
        chk("t6_cpu_rdata", cpu_rdata, 32'hC3);
        cpu_req = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
